// File: rtl/serial_addsub_arb_if.sv
// serial_addsub_arb_if
// Groups the request/operand and result signals of serial_addsub_arb.
//   req0/req1, op0/op1, a0/b0, a1/b1 : requester side (driven by master)
//   gnt0/gnt1, busy, done, owner,
//   result, cout                      : unit side (driven by slave)
//   ovf                               : present only when ADDSUB_OVF_EN is defined
interface serial_addsub_arb_if #(
    parameter int unsigned WIDTH = 8
);
    logic             req0;
    logic             req1;
    logic             op0;
    logic             op1;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             gnt0;
    logic             gnt1;
    logic             busy;
    logic             done;
    logic             owner;
    logic [WIDTH-1:0] result;
    logic             cout;
`ifdef ADDSUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output req0, req1, op0, op1, a0, b0, a1, b1,
        input  gnt0, gnt1, busy, done, owner, result, cout
`ifdef ADDSUB_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  req0, req1, op0, op1, a0, b0, a1, b1,
        output gnt0, gnt1, busy, done, owner, result, cout
`ifdef ADDSUB_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/serial_addsub_arb.sv
// serial_addsub_arb
// Bit-serial adder/subtractor shared by two requesters under round-robin arbitration.
// One bit per cycle, LSB first, through a single 1-bit full-add / full-subtract cell.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : serial_addsub_arb_if.slave (requests, operands, grants, status, result)
// Optional feature: define ADDSUB_OVF_EN to add bus.ovf, the two's-complement overflow
// of the latched operation (carry into MSB XOR carry out of MSB).
module serial_addsub_arb #(
    parameter int unsigned WIDTH = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    serial_addsub_arb_if.slave   bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             op_q, op_d;
    logic             owner_q, owner_d;
    logic             carry_q, carry_d;
    // Requester favoured when both request; flips to the other side on every grant.
    logic             rr_q, rr_d;
`ifdef ADDSUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic any_req;
    logic winner;
    logic last_bit;
    logic a_bit;
    logic b_bit;
    logic sum_bit;
    logic carry_nxt;

    // Shared 1-bit cell and arbitration decision.
    always_comb begin
        any_req   = bus.req0 | bus.req1;
        winner    = (bus.req0 & bus.req1) ? rr_q : bus.req1;
        last_bit  = (cnt_q == CntW'(WIDTH - 1));
        a_bit     = a_q[0];
        b_bit     = b_q[0];
        sum_bit   = a_bit ^ b_bit ^ carry_q;
        if (op_q) begin
            // Borrow out of a - b - borrow_in.
            carry_nxt = (~a_bit & b_bit) | (b_bit & carry_q) | (~a_bit & carry_q);
        end else begin
            carry_nxt = (a_bit & b_bit) | (b_bit & carry_q) | (a_bit & carry_q);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        op_d    = op_q;
        owner_d = owner_q;
        carry_d = carry_q;
        rr_d    = rr_q;
`ifdef ADDSUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = StShift;
                    cnt_d   = '0;
                    owner_d = winner;
                    rr_d    = ~winner;
                    op_d    = winner ? bus.op1 : bus.op0;
                    a_d     = winner ? bus.a1 : bus.a0;
                    b_d     = winner ? bus.b1 : bus.b0;
                    carry_d = 1'b0;
                end
            end
            StShift: begin
                // Operands shift out at the bottom, result bits shift in at the top.
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = {sum_bit, res_q[WIDTH-1:1]};
                carry_d = carry_nxt;
                cnt_d   = cnt_q + CntW'(1);
                if (last_bit) begin
                    state_d = StDone;
                    cnt_d   = '0;
`ifdef ADDSUB_OVF_EN
                    ovf_d   = carry_q ^ carry_nxt;
`endif
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= 1'b0;
            owner_q <= 1'b0;
            carry_q <= 1'b0;
            rr_q    <= 1'b0;
`ifdef ADDSUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            op_q    <= op_d;
            owner_q <= owner_d;
            carry_q <= carry_d;
            rr_q    <= rr_d;
`ifdef ADDSUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Outputs decode from registered state only.
    always_comb begin
        bus.gnt0   = (state_q == StShift) && (cnt_q == '0) && !owner_q;
        bus.gnt1   = (state_q == StShift) && (cnt_q == '0) && owner_q;
        bus.busy   = (state_q != StIdle);
        bus.done   = (state_q == StDone);
        bus.owner  = owner_q;
        bus.result = res_q;
        bus.cout   = carry_q;
`ifdef ADDSUB_OVF_EN
        bus.ovf    = ovf_q;
`endif
    end
endmodule

// File: tb/tb_serial_addsub_arb.sv
// tb_serial_addsub_arb
// Directed self-checking bench for serial_addsub_arb (WIDTH = 8).
module tb_serial_addsub_arb;
    localparam int unsigned W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_addsub_arb_if #(.WIDTH(W)) bus();

    serial_addsub_arb #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advances one negedge; the grant pulse must be visible there.
    task automatic expect_gnt(input logic who);
        @(negedge clk);
        chk("gnt0", {31'd0, bus.gnt0}, {31'd0, !who});
        chk("gnt1", {31'd0, bus.gnt1}, {31'd0, who});
        chk("busy_at_gnt", {31'd0, bus.busy}, 32'd1);
    endtask

    // Counts cycles from the grant cycle to done; bounded.
    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 40);
        chk("done_latency", n, W);
    endtask

    // Called at the done negedge; consumes the following IDLE cycle.
    task automatic check_result(input logic [7:0] exp_res, input logic exp_cout,
                                input logic exp_owner, input logic exp_ovf);
        chk("result", {24'd0, bus.result}, {24'd0, exp_res});
        chk("cout", {31'd0, bus.cout}, {31'd0, exp_cout});
        chk("owner", {31'd0, bus.owner}, {31'd0, exp_owner});
        chk("busy_at_done", {31'd0, bus.busy}, 32'd1);
`ifdef ADDSUB_OVF_EN
        chk("ovf", {31'd0, bus.ovf}, {31'd0, exp_ovf});
`endif
        @(negedge clk);
        chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
        chk("busy_after_done", {31'd0, bus.busy}, 32'd0);
        chk("result_held", {24'd0, bus.result}, {24'd0, exp_res});
        chk("owner_held", {31'd0, bus.owner}, {31'd0, exp_owner});
`ifdef ADDSUB_OVF_EN
        chk("ovf_held", {31'd0, bus.ovf}, {31'd0, exp_ovf});
`endif
    endtask

    // One operation from one requester; optionally corrupts operands after grant.
    task automatic single(input logic who, input logic op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp_res,
                          input logic exp_cout, input logic exp_ovf, input logic scramble);
        if (who) begin
            bus.req1 = 1'b1; bus.op1 = op; bus.a1 = a; bus.b1 = b;
        end else begin
            bus.req0 = 1'b1; bus.op0 = op; bus.a0 = a; bus.b0 = b;
        end
        expect_gnt(who);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        if (scramble) begin
            bus.a0 = 8'hff; bus.b0 = 8'hff; bus.op0 = ~op;
            bus.a1 = 8'hff; bus.b1 = 8'hff; bus.op1 = ~op;
        end
        wait_done();
        check_result(exp_res, exp_cout, who, exp_ovf);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic saw_done;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.op0  = 1'b0; bus.op1  = 1'b0;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;

        // Reset state.
        #2;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_gnt0", {31'd0, bus.gnt0}, 32'd0);
        chk("rst_gnt1", {31'd0, bus.gnt1}, 32'd0);
        chk("rst_result", {24'd0, bus.result}, 32'd0);
        chk("rst_cout", {31'd0, bus.cout}, 32'd0);
        chk("rst_owner", {31'd0, bus.owner}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Simultaneous requests held: 0, then 1, then 0 again.
        bus.req0 = 1'b1; bus.op0 = 1'b0; bus.a0 = 8'd1; bus.b0 = 8'd2;
        bus.req1 = 1'b1; bus.op1 = 1'b1; bus.a1 = 8'd7; bus.b1 = 8'd3;
        expect_gnt(1'b0);
        wait_done();
        check_result(8'd3, 1'b0, 1'b0, 1'b0);
        expect_gnt(1'b1);
        wait_done();
        check_result(8'd4, 1'b0, 1'b1, 1'b0);
        expect_gnt(1'b0);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        wait_done();
        check_result(8'd3, 1'b0, 1'b0, 1'b0);

        // Single-requester vectors.
        single(1'b0, 1'b0, 8'd100, 8'd27, 8'd127, 1'b0, 1'b0, 1'b0);
        single(1'b1, 1'b0, 8'd200, 8'd100, 8'd44, 1'b1, 1'b0, 1'b0);
        single(1'b1, 1'b1, 8'd5, 8'd9, 8'd252, 1'b1, 1'b0, 1'b0);
        single(1'b0, 1'b0, 8'd10, 8'd20, 8'd30, 1'b0, 1'b0, 1'b1);
        single(1'b1, 1'b1, 8'd200, 8'd55, 8'd145, 1'b0, 1'b0, 1'b0);
`ifdef ADDSUB_OVF_EN
        single(1'b0, 1'b0, 8'd100, 8'd100, 8'd200, 1'b0, 1'b1, 1'b0);
        single(1'b1, 1'b1, 8'd128, 8'd1, 8'd127, 1'b0, 1'b1, 1'b0);
`endif

        // Reset mid-operation at bit counter 3; last grant goes to 0.
        bus.req0 = 1'b1; bus.op0 = 1'b0; bus.a0 = 8'd7; bus.b0 = 8'd3;
        expect_gnt(1'b0);
        bus.req0 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_done", {31'd0, bus.done}, 32'd0);
        chk("midrst_result", {24'd0, bus.result}, 32'd0);
        chk("midrst_cout", {31'd0, bus.cout}, 32'd0);
        chk("midrst_gnt0", {31'd0, bus.gnt0}, 32'd0);
        chk("midrst_owner", {31'd0, bus.owner}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        chk("no_done_after_rst", {31'd0, saw_done}, 32'd0);

        // Pointer back to favouring requester 0.
        bus.req0 = 1'b1; bus.op0 = 1'b0; bus.a0 = 8'd60; bus.b0 = 8'd70;
        bus.req1 = 1'b1; bus.op1 = 1'b1; bus.a1 = 8'd3;  bus.b1 = 8'd4;
        expect_gnt(1'b0);
        bus.req0 = 1'b0;
        wait_done();
        check_result(8'd130, 1'b0, 1'b0, 1'b1);
        expect_gnt(1'b1);
        bus.req1 = 1'b0;
        wait_done();
        check_result(8'd255, 1'b1, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
